// File: rtl/accum_window_ctrl.sv
// accum_window_ctrl: sequencer for the shared accumulator datapath.
// Chops a valid/ready sample stream into windows of N samples, steers the
// external accumulator (load/en/abs/in) to form the window sum or |sum|,
// and presents each result through a hold register on a valid/ready port.
// Optional feature macro: ACC_OVF_EN adds the m_ovf signed-overflow flag.
module accum_window_ctrl #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_abs,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             acc_load,
  output logic             acc_en,
  output logic             acc_abs,
  output logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] acc_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
`ifdef ACC_OVF_EN
  output logic             m_ovf,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, LATCH} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] cnt, len, eff_len;
  logic             abs_mode;
  logic             accept;   // sample handshake this cycle
  logic             last;     // current ACCUM handshake completes the window
  logic             reload;   // hold register captures acc_out this cycle

  // A length of 0 behaves as a single-sample window.
  assign eff_len = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign last    = (cnt == len - LEN_W'(1));
  assign busy    = (state != IDLE);

  // Next state and combinational accumulator controls.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_n  = state;
    s_ready  = 1'b0;
    accept   = 1'b0;
    reload   = 1'b0;
    acc_load = 1'b0;
    acc_en   = 1'b0;
    acc_abs  = 1'b0;
    acc_in   = '0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          accept   = 1'b1;
          acc_load = 1'b1;
          acc_en   = 1'b1;
          acc_in   = s_data;
          state_n  = (eff_len == LEN_W'(1)) ? FINAL : ACCUM;
        end
      end
      ACCUM: begin
        s_ready = 1'b1;
        if (s_valid) begin
          accept = 1'b1;
          acc_en = 1'b1;
          acc_in = s_data;
          if (last) state_n = FINAL;
        end
      end
      FINAL: begin
        // acc_in stays 0, so the enabled step only applies the abs operation.
        if (abs_mode) begin
          acc_abs = 1'b1;
          acc_en  = 1'b1;
        end
        state_n = LATCH;
      end
      LATCH: begin
        if (!m_valid || m_ready) begin
          reload  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // While reset is held the controller accepts nothing and drives nothing.
    if (reset) begin
      s_ready  = 1'b0;
      accept   = 1'b0;
      reload   = 1'b0;
      acc_load = 1'b0;
      acc_en   = 1'b0;
      acc_abs  = 1'b0;
      acc_in   = '0;
    end
  end

  // State register plus per-window length/mode capture and sample counter.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= LEN_W'(1);
      abs_mode <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        if (state == IDLE) begin
          len      <= eff_len;
          abs_mode <= cfg_abs;
          cnt      <= (eff_len == LEN_W'(1)) ? '0 : LEN_W'(1);
        end else begin
          // Wrap on the final sample so cnt never exceeds len-1.
          cnt <= last ? '0 : cnt + LEN_W'(1);
        end
      end
    end
  end

  // Result hold register; a reload in LATCH wins over a same-cycle consume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (reload) begin
      m_valid <= 1'b1;
      m_data  <= acc_out;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef ACC_OVF_EN
  logic             ovf_flag;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf, abs_ovf;

  // Signed overflow: operands share a sign and the wrapped sum does not.
  assign add_sum = acc_out + s_data;
  assign add_ovf = (acc_out[WIDTH-1] == s_data[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != s_data[WIDTH-1]);
  assign abs_ovf = (acc_out == {1'b1, {(WIDTH-1){1'b0}}});

  // Sticky per-window overflow flag, captured alongside m_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_flag <= 1'b0;
      m_ovf    <= 1'b0;
    end else begin
      if (accept && state == IDLE)                    ovf_flag <= 1'b0;
      else if (accept && state == ACCUM && add_ovf)   ovf_flag <= 1'b1;
      else if (state == FINAL && abs_mode && abs_ovf) ovf_flag <= 1'b1;
      if (reload) m_ovf <= ovf_flag;
    end
  end
`else
  // Overflow tracking is not built; results carry no overflow indication.
`endif

endmodule

// File: doc/accum_window_ctrl.md
Name: accum_window_ctrl

Overview:
- Sequencer for the shared accumulator datapath.
- Accepts a valid/ready sample stream and chops it into windows of N samples. For each window it drives the accumulator's load/en/abs/in controls to form the window sum, or the absolute value of the sum.
- Captures each result into a hold register and presents it on a valid/ready output port.
- Sits between the sample source and downstream DSP stages; the accumulator itself is instantiated alongside it.

Parameters:
- WIDTH, 32, data width of samples, accumulator and result.
- LEN_W, 8, width of the window-length config field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cfg_len  input  LEN_W  window length N; 0 is treated as 1; sampled at each window's first sample.
- cfg_abs  input  1  1 = result is |sum|; sampled with cfg_len.
- s_valid  input  1  sample valid.
- s_ready  output  1  sample accepted when s_valid && s_ready.
- s_data  input  WIDTH  sample, two's complement.
- acc_load  output  1  accumulator load (acc <= acc_in); priority over en.
- acc_en  output  1  accumulator enable (acc <= acc + acc_in).
- acc_abs  output  1  accumulator absolute-value step.
- acc_in  output  WIDTH  accumulator operand.
- acc_out  input  WIDTH  accumulator registered output; reflects controls one edge later.
- m_valid  output  1  result valid.
- m_ready  input  1  result consumed when m_valid && m_ready.
- m_data  output  WIDTH  result hold register.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset, asynchronous, any state: state=IDLE, cnt=0, m_valid=0, m_data=0, and all acc_* outputs 0. A partial window in progress is discarded. The stale accumulator value is harmless because the next window starts with acc_load.
- States: IDLE, ACCUM, FINAL, LATCH.
- IDLE: s_ready=1. On handshake:
  - drive acc_load=1, acc_en=1, acc_in=s_data;
  - latch len and abs_mode; set cnt=1;
  - next state is FINAL if len==1, else ACCUM.
- ACCUM: s_ready=1. On handshake:
  - drive acc_en=1, acc_in=s_data; cnt<=cnt+1;
  - when cnt==len-1 on that handshake, go to FINAL.
  - With no handshake: acc_en=0 and state holds.
- FINAL: s_ready=0.
  - If abs_mode: acc_abs=1, acc_en=1, acc_in=0.
  - Otherwise: all acc_* controls 0.
  - Always goes to LATCH after one cycle.
- LATCH: s_ready=0; acc_* outputs 0.
  - If !m_valid or m_ready: m_data<=acc_out, m_valid<=1, go to IDLE.
  - Otherwise stall in LATCH (backpressure).
- Output handshake: m_valid clears on m_valid && m_ready unless a LATCH reload occurs in the same cycle; reload wins and m_valid stays 1. m_data is stable while m_valid && !m_ready.
- Latency: the final sample handshake at edge k gives m_valid=1 after edge k+2 when unstalled.
- A new window may start in IDLE while the previous result is still pending on m_valid.
- acc_* outputs are combinational from state and s_valid. acc_load and acc_en are never asserted without an accepted sample, except in the FINAL abs step.
- Arithmetic is the accumulator's: modulo 2^WIDTH wrap. |most-negative| equals itself.
- cnt is LEN_W bits wide and never exceeds len-1.
- Throughput: N+2 cycles per window, plus any output stalls.

Optional Feature:
- Macro: ACC_OVF_EN.
- Defined:
  - Adds output m_ovf (1 bit), captured together with m_data and reset to 0.
  - A sticky per-window flag sets on any ACCUM add where acc_out and acc_in have equal sign bits and the true sum's sign differs.
  - The flag also sets when the FINAL abs step is applied to the most-negative value.
  - The flag clears when a new window's first sample is loaded.
- Undefined: m_ovf port and the overflow logic are absent.

Test Plan:
- cfg_len=4, cfg_abs=0, samples 1,2,3,4 back-to-back, m_ready=1 -> m_data=0000000A, m_valid one cycle, 3 cycles after the 4th accept; s_ready low in FINAL and LATCH.
- cfg_len=2, cfg_abs=1, samples FFFFFFF0, FFFFFFFF -> m_data=00000011; acc_abs pulses exactly once.
- cfg_len=3, samples 5,6,7 with s_valid gaps of 2 cycles, then a second window 1,1,1 with m_ready=0 -> first m_data=00000012 held stable; controller stalls in LATCH; after m_ready=1, second m_data=00000003.
- cfg_len=0, sample 00001234 -> treated as N=1, m_data=00001234; cfg_len changed mid-window has no effect until the next window.
- reset asserted after 2 of 4 samples -> outputs 0 immediately (async); next window 7,7,7,7 -> m_data=0000001C, with no carry-over.
- ACC_OVF_EN: cfg_len=2, samples 7FFFFFFF, 00000001 -> m_data=80000000, m_ovf=1; next window 1,1 -> m_ovf=0.
